// File: rtl/bus_cmd_initiator.sv
// bus_cmd_initiator: command-driven initiator for the 19-bit peripheral bus.
// Commands (WRITE / READ / WAIT_IRQ) arrive through a small FIFO, are executed one at
// a time as single-cycle bus strobes or interrupt waits, and results leave through a
// response FIFO.
module bus_cmd_initiator #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [18:0] cmd_addr,
    input  logic [18:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [18:0] rsp_data,
    output logic        rsp_err,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [18:0] bus_addr,
    output logic [18:0] bus_wdata,
    input  logic [18:0] bus_rdata,
    input  logic        irq_in,
    output logic        busy
);

    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0] CMD_FULL = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW:0] RSP_FULL = (RAW + 1)'(RSP_DEPTH);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Command FIFO
    logic [1:0]     cmd_op_mem   [CMD_DEPTH];
    logic [18:0]    cmd_addr_mem [CMD_DEPTH];
    logic [18:0]    cmd_data_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wptr_q, cmd_rptr_q;
    logic [CAW:0]   cmd_cnt_q;
    logic           cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [1:0]     head_op;
    logic [18:0]    head_addr, head_data;

    // Response FIFO, entries are {data, err}
    logic [19:0]    rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] rsp_wptr_q, rsp_rptr_q;
    logic [RAW:0]   rsp_cnt_q;
    logic           rsp_empty, rsp_full, rsp_push, rsp_pop;
    logic [18:0]    rsp_push_data;
    logic           rsp_push_err;

    // Sequencer state
    logic [1:0]  state_q, state_d;
    logic [18:0] wcnt_q, wcnt_d;
    logic [18:0] tmo_q, tmo_d;
    logic [19:0] wcnt_inc;
    logic        irq_pending_q, irq_pending_d, irq_take;
    logic        bus_valid_q, bus_write_q;
    logic [18:0] bus_addr_q, bus_wdata_q;
    logic        nxt_valid, nxt_write;
    logic [18:0] nxt_addr, nxt_wdata;

    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == CMD_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign cmd_ready = !cmd_full || cmd_pop;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign head_op   = cmd_op_mem[cmd_rptr_q];
    assign head_addr = cmd_addr_mem[cmd_rptr_q];
    assign head_data = cmd_data_mem[cmd_rptr_q];

    assign rsp_empty = (rsp_cnt_q == '0);
    assign rsp_full  = (rsp_cnt_q == RSP_FULL);
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_mem[rsp_rptr_q][19:1];
    assign rsp_err   = rsp_mem[rsp_rptr_q][0];

    assign bus_valid = bus_valid_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = !cmd_empty || (state_q != ST_IDLE);

    assign wcnt_inc = {1'b0, wcnt_q} + 20'd1;

    // Next-state decode: command dispatch, bus strobe, interrupt wait
    always_comb begin
        state_d       = state_q;
        cmd_pop       = 1'b0;
        rsp_push      = 1'b0;
        rsp_push_data = '0;
        rsp_push_err  = 1'b0;
        nxt_valid     = 1'b0;
        nxt_write     = 1'b0;
        nxt_addr      = '0;
        nxt_wdata     = '0;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        irq_take      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    case (head_op)
                        OP_WRITE: begin
                            cmd_pop   = 1'b1;
                            nxt_valid = 1'b1;
                            nxt_write = 1'b1;
                            nxt_addr  = head_addr;
                            nxt_wdata = head_data;
                            state_d   = ST_BUS;
                        end
                        // Responding ops reserve a response slot before they are popped.
                        OP_READ: begin
                            if (!rsp_full) begin
                                cmd_pop   = 1'b1;
                                nxt_valid = 1'b1;
                                nxt_addr  = head_addr;
                                state_d   = ST_BUS;
                            end
                        end
                        OP_WAIT: begin
                            if (!rsp_full) begin
                                cmd_pop = 1'b1;
                                wcnt_d  = '0;
                                tmo_d   = head_data;
                                state_d = ST_WAIT;
                            end
                        end
                        default: begin
                            if (!rsp_full) begin
                                cmd_pop      = 1'b1;
                                rsp_push     = 1'b1;
                                rsp_push_err = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_BUS: begin
                if (!bus_write_q) begin
                    rsp_push      = 1'b1;
                    rsp_push_data = bus_rdata;
                end
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (irq_pending_q || irq_in) begin
                    rsp_push      = 1'b1;
                    rsp_push_data = wcnt_q;
                    irq_take      = 1'b1;
                    state_d       = ST_IDLE;
                end else if (tmo_q != '0 && wcnt_inc == {1'b0, tmo_q}) begin
                    rsp_push      = 1'b1;
                    rsp_push_data = tmo_q;
                    rsp_push_err  = 1'b1;
                    state_d       = ST_IDLE;
                end else if (wcnt_q != 19'h7FFFF) begin
                    wcnt_d = wcnt_inc[18:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_pending_d = irq_take ? 1'b0 : (irq_pending_q | irq_in);
    end

    // Sequencer and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            tmo_q         <= '0;
            irq_pending_q <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            tmo_q         <= tmo_d;
            irq_pending_q <= irq_pending_d;
            bus_valid_q   <= nxt_valid;
            bus_write_q   <= nxt_write;
            bus_addr_q    <= nxt_addr;
            bus_wdata_q   <= nxt_wdata;
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
                2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Command FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wptr_q]   <= cmd_op;
            cmd_addr_mem[cmd_wptr_q] <= cmd_addr;
            cmd_data_mem[cmd_wptr_q] <= cmd_data;
        end
    end

    // Response FIFO pointers and occupancy; reset drops any in-flight push
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            if (rsp_push) rsp_wptr_q <= rsp_wptr_q + 1'b1;
            if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
                2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem[rsp_wptr_q] <= {rsp_push_data, rsp_push_err};
    end

endmodule

// File: doc/bus_cmd_initiator.md
Name: bus_cmd_initiator

Overview:
Command-driven bus initiator for the 19-bit peripheral bus. The timer and other memory-mapped peripherals are responders on this bus.
- Accepts WRITE, READ and WAIT_IRQ commands through a valid/ready command FIFO.
- Issues single-cycle bus transactions and waits on a peripheral interrupt pulse.
- Returns read data and wait results through a valid/ready response FIFO.
- Sits between the control sequencer (or test host) and the peripheral bus.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  2  00 WRITE, 01 READ, 10 WAIT_IRQ, 11 illegal
cmd_addr  in  19  bus address
cmd_data  in  19  write data (WRITE) / timeout cycles (WAIT_IRQ, 0 = no timeout)
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  consumer accepts head response
rsp_data  out  19  read data / cycles waited
rsp_err  out  1  timeout or illegal op
bus_valid  out  1  transaction strobe, one cycle
bus_write  out  1  1 = write, 0 = read
bus_addr  out  19  transaction address
bus_wdata  out  19  write data
bus_rdata  in  19  combinational read data from responder, valid while bus_valid && !bus_write
irq_in  in  1  single-cycle interrupt pulse from peripheral
busy  out  1  command FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (synchronous, takes effect at the next edge):
  - Both FIFOs emptied; FSM to IDLE; irq_pending and wait counter cleared.
  - bus_valid, bus_write, bus_addr and bus_wdata are 0.
  - rsp_valid=0, cmd_ready=1, busy=0.
  - Reset mid-transaction aborts it: bus_valid is 0 in the cycle after the reset edge, and no response is produced.
- Command FIFO:
  - Push on cmd_valid && cmd_ready.
  - An entry pushed at edge T is visible to the FSM in cycle T+1.
  - Simultaneous push and pop are allowed when full.
- Response FIFO:
  - Pop on rsp_valid && rsp_ready.
  - rsp_data and rsp_err show the head entry.
- Bus outputs are registered. bus_valid is high for exactly one cycle per transaction. bus_addr, bus_wdata and bus_write are 0 whenever bus_valid is 0.
- FSM states: IDLE, BUS, WAIT.
  - IDLE, command FIFO non-empty: examine the head.
    - WRITE: pop; drive bus_valid=1, bus_write=1, addr and data in the next cycle; go to BUS.
    - READ: pop only if the response FIFO is not full, otherwise stall in IDLE; drive bus_valid=1, bus_write=0 next cycle; go to BUS.
    - WAIT_IRQ: pop only if the response FIFO is not full; go to WAIT with the counter at 0.
    - Illegal op: pop only if the response FIFO is not full; push response {data=0, err=1}; stay in IDLE.
  - BUS (bus_valid high this cycle): for a READ, sample bus_rdata at the end-of-cycle edge and push {bus_rdata, err=0}; WRITE pushes nothing. Go to IDLE.
  - Throughput: at most one bus transaction every 2 cycles. Latency: a command pushed at edge T gives bus_valid high in cycle T+2 and rsp_valid high in cycle T+3.
  - WAIT, evaluated each cycle:
    - If irq_pending or irq_in: push {counter, err=0}, clear irq_pending, go to IDLE.
    - Else if timeout≠0 and counter+1 == timeout: push {timeout, err=1}, go to IDLE.
    - Else counter increments. With timeout 0 the counter saturates at 19'h7FFFF.
- irq_pending:
  - Set by irq_in in any cycle the FSM is not consuming it in WAIT; it is sticky, so multiple pulses collapse to one.
  - A pending flag at WAIT entry completes in the first WAIT cycle with data=0.
  - irq_in coinciding with the timeout cycle counts as success (err=0).
- Only one transaction is outstanding at a time. Checking "response FIFO not full" at pop guarantees the later push never overflows.
- Arithmetic: all counters are 19-bit unsigned with no wrap (saturate as stated).
- busy deasserts only when the FSM is in IDLE and the command FIFO is empty; responses may still be queued.

Test Plan:
- Reset, then WRITE addr=0x4 data=1000 → bus_valid one cycle with bus_write=1, addr=0x00004, wdata=0x003E8; no response; busy returns to 0.
- READ addr=0x0 with responder returning 0x12345 → rsp_valid 3 cycles after the push; rsp_data=0x12345, rsp_err=0; bus_write=0 during the strobe.
- WAIT_IRQ timeout=10 with irq_in pulsed 6 cycles after WAIT entry → rsp_data=6, err=0. Repeat with no irq → rsp_data=10, err=1.
- irq_in pulse while idle, then WAIT_IRQ timeout=0 → immediate response data=0, err=0; irq_pending cleared.
- Hold rsp_ready=0 and queue 6 READs (RSP_DEPTH=4) → exactly 4 bus reads, FSM stalls and cmd_ready drops once full. Release rsp_ready → remaining 2 reads complete and responses come out in order.
- Illegal op 11 → response data=0, err=1, no bus activity. Assert rst in the BUS cycle of a READ → bus_valid 0 the next cycle, FIFOs empty, no response.
